// File: rtl/isp_uart_host.sv
// isp_uart_host: host side of the on-chip UART debug port.
// Turns a binary request into the debug port's ASCII line (read, write or a
// one-letter control command), shifts it out 8N1, then collects the 8-char
// ASCII reply and returns binary read data plus an error flag.
// Optional feature macro: ISP_UART_HOST_ECHO_CHECK_EN -- when defined, the
// replies to write/reset/run/stop must match their fixed echo text exactly.
// The receive deserializer (uart_rx) is deliberately not tied to rst, so a
// byte in flight across a reset completes and is then dropped in IDLE.

module uart_rx #(
  parameter int CLK_DIV = 108
) (
  input  logic       clk,
  input  logic       i_rx,
  output logic       o_ready,
  output logic [7:0] o_data
);
  // One bit lasts 4*CLK_DIV cycles; sample the start bit at its middle,
  // then every full bit period after that.
  localparam int FULL = 4 * CLK_DIV;
  localparam int HALF = 2 * CLK_DIV;
  localparam int CW   = $clog2(FULL + 1);

  logic [1:0]    sync;
  logic          busy;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_end;
  logic [3:0]    bit_idx;
  logic [7:0]    sh;

  assign cnt_end = (bit_idx == 4'd0) ? CW'(HALF - 1) : CW'(FULL - 1);

  // Self-recovering deserializer: any state drains back to idle on its own.
  always_ff @(posedge clk) begin
    sync    <= {sync[0], i_rx};
    o_ready <= 1'b0;
    if (!busy) begin
      cnt     <= '0;
      bit_idx <= '0;
      busy    <= ~sync[1];
    end else if (cnt != cnt_end) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
      if (bit_idx == 4'd0) begin
        busy    <= ~sync[1];           // glitch, not a real start bit
        bit_idx <= 4'd1;
      end else if (bit_idx < 4'd9) begin
        sh      <= {sync[1], sh[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end else begin
        busy    <= 1'b0;
        o_ready <= sync[1];            // drop frames with a bad stop bit
        o_data  <= sh;
      end
    end
  end
endmodule

module isp_uart_host #(
  parameter int UART_RX_CLK_DIV = 108,
  parameter int UART_TX_CLK_DIV = 434,
  parameter int RESP_TIMEOUT    = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_uart_rx,
  output logic        o_uart_tx,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_cmd,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int DW = (UART_TX_CLK_DIV > 1) ? $clog2(UART_TX_CLK_DIV) : 1;
  localparam int TW = $clog2(RESP_TIMEOUT + 1);

  localparam logic [2:0] CMD_READ  = 3'd0;
  localparam logic [2:0] CMD_WRITE = 3'd1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_RESP, S_DONE} state_t;

  state_t          state;
  logic [2:0]      cmd_q;
  logic [17:0][7:0] line_q, line_d;
  logic [4:0]      len_q, len_d;
  logic            legal_d;
  logic [4:0]      byte_idx;
  logic [3:0]      bit_cnt;
  logic [DW-1:0]   div_cnt;
  logic [TW-1:0]   tcnt;
  logic [2:0]      rcnt;
  logic [31:0]     rd_sh, sh_n;
  logic            err_acc, err_n, chr_err;
  logic            rx_ready;
  logic [7:0]      rx_data;
  logic            rx_is_hex;
  logic [3:0]      rx_nib;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

`ifdef ISP_UART_HOST_ECHO_CHECK_EN
  function automatic logic [7:0] echo_char(input logic [2:0] cmd, input logic [2:0] idx);
    logic [63:0] s;
    case (cmd)
      3'd1:    s = "wr done ";
      3'd2:    s = "rst done";
      3'd3:    s = "running ";
      default: s = "stoped  ";
    endcase
    return s[63 - 8 * int'(idx) -: 8];
  endfunction
`endif

  uart_rx #(.CLK_DIV(UART_RX_CLK_DIV)) u_rx (
    .clk     (clk),
    .i_rx    (i_uart_rx),
    .o_ready (rx_ready),
    .o_data  (rx_data)
  );

  // Build the command line straight from the request so the start bit can
  // go out the cycle after acceptance.
  always_comb begin
    line_d  = '0;
    len_d   = 5'd2;
    legal_d = 1'b1;
    case (req_cmd)
      3'd0: begin
        for (int i = 0; i < 8; i++) line_d[i] = hex_char(req_addr[31 - 4 * i -: 4]);
        line_d[8] = 8'h0a;
        len_d     = 5'd9;
      end
      3'd1: begin
        for (int i = 0; i < 8; i++) begin
          line_d[i]     = hex_char(req_addr[31 - 4 * i -: 4]);
          line_d[9 + i] = hex_char(req_wdata[31 - 4 * i -: 4]);
        end
        line_d[8]  = 8'h20;
        line_d[17] = 8'h0a;
        len_d      = 5'd18;
      end
      3'd2: begin line_d[0] = "r"; line_d[1] = 8'h0a; end
      3'd3: begin line_d[0] = "w"; line_d[1] = 8'h0a; end
      3'd4: begin line_d[0] = "s"; line_d[1] = 8'h0a; end
      default: legal_d = 1'b0;
    endcase
  end

  // Classify the received char and form the next shift/error state.
  always_comb begin
    rx_is_hex = ((rx_data >= 8'h30) && (rx_data <= 8'h39)) ||
                ((rx_data >= 8'h61) && (rx_data <= 8'h66));
    rx_nib    = (rx_data <= 8'h39) ? rx_data[3:0] : (rx_data[3:0] + 4'd9);
    chr_err   = 1'b0;
    if (cmd_q == CMD_READ) chr_err = ~rx_is_hex;
`ifdef ISP_UART_HOST_ECHO_CHECK_EN
    else chr_err = (rx_data != echo_char(cmd_q, rcnt));
`endif
    sh_n  = {rd_sh[27:0], rx_nib};
    err_n = err_acc | chr_err;
  end

  // Main FSM: accept, serialize, collect reply, pulse response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      o_uart_tx  <= 1'b1;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      cmd_q      <= '0;
      line_q     <= '0;
      len_q      <= '0;
      byte_idx   <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      tcnt       <= '0;
      rcnt       <= '0;
      rd_sh      <= '0;
      err_acc    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cmd_q     <= req_cmd;
            line_q    <= line_d;
            len_q     <= len_d;
            req_ready <= 1'b0;
            byte_idx  <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            rcnt      <= '0;
            rd_sh     <= '0;
            if (legal_d) begin
              err_acc   <= 1'b0;
              o_uart_tx <= 1'b0;       // start bit of byte 0
              state     <= S_SEND;
            end else begin
              err_acc <= 1'b1;
              state   <= S_DONE;
            end
          end
        end
        S_SEND: begin
          if (div_cnt == DW'(UART_TX_CLK_DIV - 1)) begin
            div_cnt <= '0;
            if (bit_cnt == 4'd9) begin
              if (byte_idx == len_q - 5'd1) begin
                tcnt  <= '0;
                state <= S_WAIT_RESP;
              end else begin
                byte_idx  <= byte_idx + 1'b1;
                bit_cnt   <= '0;
                o_uart_tx <= 1'b0;     // next start bit, no idle gap
              end
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              o_uart_tx <= (bit_cnt == 4'd8) ? 1'b1 : line_q[byte_idx][bit_cnt[2:0]];
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_WAIT_RESP: begin
          if (rx_ready) begin
            tcnt <= '0;
            // Leading CR/LF left over from a previous line are skipped.
            if (!((rcnt == 3'd0) && ((rx_data == 8'h0d) || (rx_data == 8'h0a)))) begin
              rcnt    <= rcnt + 1'b1;
              rd_sh   <= sh_n;
              err_acc <= err_n;
              if (rcnt == 3'd7) begin
                state      <= S_DONE;
                resp_valid <= 1'b1;
                resp_err   <= err_n;
                resp_rdata <= ((cmd_q == CMD_READ) && !err_n) ? sh_n : 32'h0;
              end
            end
          end else if (tcnt == TW'(RESP_TIMEOUT - 1)) begin
            state      <= S_DONE;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_DONE: begin
          // Illegal commands arrive here without the pulse set yet.
          if (!resp_valid) begin
            resp_valid <= 1'b1;
            resp_err   <= err_acc;
            resp_rdata <= '0;
          end else begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic unused_cmd;
  assign unused_cmd = (cmd_q == CMD_WRITE);
endmodule

// File: doc/isp_uart_host.md
# isp_uart_host

Host-side counterpart of the on-chip UART debug port: turns binary bus-style requests into the debug port's ASCII command lines, sends them over UART, and parses the 8-character ASCII reply back into binary data and a status flag. It is used as the stimulus/loader engine in SoC-level benches and in the FPGA self-test harness, where its `o_uart_tx`/`i_uart_rx` connect crosswise to the target's debug UART pins.

## Interface
- `UART_RX_CLK_DIV`, 108, rx oversample divider passed to the internal `uart_rx` instance (clk/4/baud).
- `UART_TX_CLK_DIV`, 434, clk cycles per transmitted bit (clk/baud).
- `RESP_TIMEOUT`, 2000000, idle-line cycles tolerated while waiting for a reply.

- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `i_uart_rx` in 1: serial from target; idle high.
- `o_uart_tx` in/out: out 1: serial to target, 8N1, LSB first; idle high.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_cmd` in 3: 0 read, 1 write, 2 reset (`r`), 3 run (`w`), 4 stop (`s`), 5-7 illegal.
- `req_addr` in 32: read/write address.
- `req_wdata` in 32: write data.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: parsed read data; 0 for all non-read commands and on error.
- `resp_err` out 1: qualified by `resp_valid`; timeout, malformed or mismatched reply.

## Operation
- FSM: IDLE, SEND, WAIT_RESP, DONE.
- IDLE: `req_ready`=1; on `req_valid`, latch cmd/addr/wdata and build the line; illegal cmd goes straight to DONE with err=1.
- Line formats, lowercase hex, MSB nibble first:
  - read: 8 addr digits + `\n` (9 bytes)
  - write: 8 addr digits, space, 8 data digits, `\n` (18 bytes)
  - ctrl: letter + `\n` (2 bytes)
- SEND: serialize bytes back to back: start(0), 8 data bits, stop(1), each bit `UART_TX_CLK_DIV` cycles. After the last stop bit, go to WAIT_RESP.
- WAIT_RESP: take received bytes from `uart_rx` (`o_ready` pulse, `o_data`).
  - While the char count is 0, drop `\r` and `\n`; every other byte is stored.
  - The 8th stored char completes the reply and moves the FSM to DONE.
  - Read: each char must be `0`-`9` or `a`-`f`; shift nibble into rdata. Any other char (uppercase included) sets err and rdata=0.
- DONE: pulse `resp_valid` for one cycle, then return to IDLE.
- Bytes received in IDLE, SEND or DONE are discarded.
- Timeout counter:
  - cleared on entry to WAIT_RESP and on each received byte.
  - reaching `RESP_TIMEOUT` goes to DONE with err=1 and rdata=0.

## Timing
- Reset values: `o_uart_tx`=1, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, FSM=IDLE, counters=0.
- Accept cycle: `req_valid && req_ready`; `req_ready` drops the next cycle.
- Start bit of byte 0 appears on `o_uart_tx` the cycle after the accept cycle.
- TX duration is exactly N×10×`UART_TX_CLK_DIV` cycles for N bytes. No gap between stop bit and next start bit.
- `resp_valid` rises the cycle after the completing rx byte's ready pulse, or after the timeout hit. `req_ready` rises the cycle after `resp_valid`.
- Illegal cmd: `resp_valid`+err two cycles after the accept cycle; line stays high.
- Async `rst` mid-frame: line forced high immediately and the partial frame is abandoned. The internal `uart_rx` is not reset; any byte it completes after reset is discarded in IDLE.

## Configuration
- `ISP_UART_HOST_ECHO_CHECK_EN`
- Defined: write replies must equal `wr done `, reset `rst done`, run `running `, stop `stoped  `, byte-exact; any mismatch sets err.
- Undefined: any 8 non-CR/LF chars complete a non-read command with err=0. The read hex check is unaffected.

## Test plan
- Read of 0x00000100; target model replies `928cd0f1\n` -> line bytes `00000100\n`; `resp_rdata`=0x928cd0f1, err=0, TX time 39060 cycles at default div.
- Write 0x00000104=0xdeadbeef; reply `wr done ` -> line `00000104 deadbeef\n` (18 bytes); err=0, rdata=0. With macro and reply `wr_done ` -> err=1.
- Reset cmd; reply preceded by `\r\n` then `rst done` -> line `r\n`; leading CR/LF ignored; err=0.
- Read; reply `928CD0F1` -> err=1, rdata=0. Read with silent line -> err=1 exactly `RESP_TIMEOUT` cycles after last stop bit.
- `req_cmd`=6 -> no line activity; `resp_valid`+err=1 two cycles after accept.
- Assert `rst` during byte 3 of a write -> `o_uart_tx`=1 same cycle; `req_ready`=1; next read completes normally.
